// File: rtl/alu_requester_pkg.sv
// alu_requester_pkg: shared opcode, status and state types for the ALU requester.
package alu_requester_pkg;
    typedef enum logic [2:0] {NOP = 3'd0, ADD = 3'd1, AND = 3'd2, XOR = 3'd3, MUL = 3'd4} op_t;
    typedef enum logic [1:0] {OK = 2'd0, ILLEGAL = 2'd1, TIMEOUT = 2'd2} status_t;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
    function automatic logic is_alu_op(op_t op);
        return op inside {ADD, AND, XOR, MUL};
    endfunction
endpackage

// File: rtl/alu_requester_if.sv
// alu_requester_if: command, ALU start/done and response signals of the requester.
interface alu_requester_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        done;
    logic [15:0] result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_status;
    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, done, result, rsp_ready,
        output cmd_ready, start, op, A, B, rsp_valid, rsp_result, rsp_status
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, done, result, rsp_ready,
        input  cmd_ready, start, op, A, B, rsp_valid, rsp_result, rsp_status
    );
endinterface

// File: rtl/alu_requester_timer.sv
// alu_req_timer: counts start-high cycles; expired marks the last allowed cycle
// so start drops after exactly TIMEOUT_CKS cycles.
module alu_req_timer #(
    parameter int TIMEOUT_CKS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT_CKS + 1);
    logic [W-1:0] r_count;
    always_ff @(posedge clk) begin
        if (reset || i_clear) r_count <= '0;
        else if (i_enable) r_count <= r_count + W'(1);
    end
    assign o_expired = i_enable && (r_count == W'(TIMEOUT_CKS - 1));
endmodule

// File: rtl/alu_requester.sv
// alu_requester: issues one command at a time to the ALU over start/done and
// returns the captured result with a status on a valid/ready response port.
module alu_requester
    import alu_requester_pkg::*;
#(
    parameter int TIMEOUT_CKS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_requester_if.master        bus,
    output logic                   o_stray_done
);
    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_start;
    logic [2:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_result;
    status_t     r_rsp_status;
    logic        r_stray_done;
    logic        w_accept;
    logic        w_issue;
    logic        w_expired;
    assign w_accept = (r_state == IDLE) && r_cmd_ready && bus.cmd_valid;
    assign w_issue  = (r_state == ISSUE);
    alu_req_timer #(.TIMEOUT_CKS(TIMEOUT_CKS)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_enable  (w_issue),
        .o_expired (w_expired)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b1;
            r_start      <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_status <= OK;
            r_stray_done <= 1'b0;
        end else begin
            r_stray_done <= bus.done && !r_start;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op        <= bus.cmd_op;
                    r_a         <= bus.cmd_a;
                    r_b         <= bus.cmd_b;
                    r_cmd_ready <= 1'b0;
                    if (is_alu_op(op_t'(bus.cmd_op))) begin
                        r_start <= 1'b1;
                        r_state <= ISSUE;
                    end else begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= '0;
                        r_rsp_status <= (bus.cmd_op == NOP) ? OK : ILLEGAL;
                        r_state      <= RESP;
                    end
                end
                // done takes priority over a timeout on the same edge
                ISSUE: if (bus.done || w_expired) begin
                    r_start      <= 1'b0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= bus.done ? bus.result : 16'h0000;
                    r_rsp_status <= bus.done ? OK : TIMEOUT;
                    r_state      <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.cmd_ready  = r_cmd_ready && !reset;
    assign bus.start      = r_start;
    assign bus.op         = r_op;
    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_status = r_rsp_status;
    assign o_stray_done   = r_stray_done;
endmodule

// File: tb/tb_alu_requester.sv
// tb_alu_requester: directed scoreboard bench for alu_requester.
module tb_alu_requester;
    typedef struct packed {
        logic [15:0] res;
        logic [1:0]  st;
    } exp_t;

    logic clk;
    logic reset;
    logic stray_done;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    alu_requester_if u_if ();

    alu_requester #(.TIMEOUT_CKS(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (u_if),
        .o_stray_done (stray_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'd1:    return {8'h00, a} + {8'h00, b};
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return a * b;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_op    = op;
        u_if.cmd_a     = a;
        u_if.cmd_b     = b;
        chk("cmd_ready_idle", 32'(u_if.cmd_ready), 1);
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        chk("op_a_b_reg", 32'({u_if.op, u_if.A, u_if.B}), 32'({op, a, b}));
    endtask

    task automatic alu_respond(string tag, int lat, logic [15:0] res);
        int w = 0;
        for (int i = 0; i < lat; i++) begin
            if (u_if.start) w++;
            if (i == lat - 1) begin
                u_if.done   = 1'b1;
                u_if.result = res;
            end
            @(negedge clk);
        end
        u_if.done = 1'b0;
        chk($sformatf("%s_start_width", tag), 32'(w), 32'(lat));
        chk($sformatf("%s_start_low", tag), 32'(u_if.start), 0);
    endtask

    task automatic get_rsp(string tag);
        exp_t e;
        int   n = 0;
        while (!u_if.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_rsp_valid", tag), 32'(u_if.rsp_valid), 1);
        chk($sformatf("%s_sb_nonempty", tag), 32'(sb.size() > 0), 1);
        if (u_if.rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_result", tag), 32'(u_if.rsp_result), 32'(e.res));
            chk($sformatf("%s_status", tag), 32'(u_if.rsp_status), 32'(e.st));
        end
        u_if.rsp_ready = 1'b1;
        @(negedge clk);
        u_if.rsp_ready = 1'b0;
        chk($sformatf("%s_rsp_drop", tag), 32'(u_if.rsp_valid), 0);
        chk($sformatf("%s_cmd_ready_back", tag), 32'(u_if.cmd_ready), 1);
    endtask

    initial begin
        int w;
        reset          = 1'b1;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_op    = 3'd0;
        u_if.cmd_a     = 8'h00;
        u_if.cmd_b     = 8'h00;
        u_if.done      = 1'b0;
        u_if.result    = 16'h0000;
        u_if.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 32'(u_if.cmd_ready), 0);
        chk("reset_outputs", 32'({u_if.start, u_if.rsp_valid, stray_done, u_if.rsp_status}), 0);
        chk("reset_op_a_b", 32'({u_if.op, u_if.A, u_if.B}), 0);
        chk("reset_rsp_result", 32'(u_if.rsp_result), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", 32'(u_if.cmd_ready), 1);

        // ADD, done one cycle after start
        send(3'd1, 8'h12, 8'h34);
        sb.push_back('{16'h0046, 2'd0});
        chk("add_cmd_ready_busy", 32'(u_if.cmd_ready), 0);
        alu_respond("add", 1, alu_fn(3'd1, 8'h12, 8'h34));
        get_rsp("add");

        // MUL, done after three start-high cycles
        send(3'd4, 8'hFF, 8'hFF);
        sb.push_back('{16'hFE01, 2'd0});
        alu_respond("mul", 3, alu_fn(3'd4, 8'hFF, 8'hFF));
        get_rsp("mul");

        // illegal opcode and NOP answer next cycle without a start pulse
        send(3'd6, 8'h11, 8'h22);
        sb.push_back('{16'h0000, 2'd1});
        chk("ill_no_start", 32'(u_if.start), 0);
        chk("ill_rsp_next", 32'(u_if.rsp_valid), 1);
        get_rsp("ill");
        send(3'd0, 8'h55, 8'hAA);
        sb.push_back('{16'h0000, 2'd0});
        chk("nop_no_start", 32'(u_if.start), 0);
        chk("nop_rsp_next", 32'(u_if.rsp_valid), 1);
        get_rsp("nop");

        // ALU never answers: start held exactly TIMEOUT_CKS cycles
        send(3'd3, 8'h0F, 8'hF0);
        sb.push_back('{16'h0000, 2'd2});
        w = 0;
        for (int i = 0; i < 20; i++) begin
            if (u_if.start) w++;
            @(negedge clk);
        end
        chk("tmo_start_width", 32'(w), 8);
        get_rsp("tmo");

        // done arriving on the timeout edge still wins
        send(3'd2, 8'hF0, 8'h3C);
        sb.push_back('{16'h0030, 2'd0});
        alu_respond("edge", 8, alu_fn(3'd2, 8'hF0, 8'h3C));
        get_rsp("edge");

        // response backpressure with a stray done pulse in the middle
        send(3'd1, 8'h80, 8'h80);
        sb.push_back('{16'h0100, 2'd0});
        alu_respond("bp", 2, alu_fn(3'd1, 8'h80, 8'h80));
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(u_if.rsp_valid), 1);
            chk("bp_hold_result", 32'({u_if.rsp_result, u_if.rsp_status}), 32'({16'h0100, 2'd0}));
            chk("bp_cmd_ready", 32'(u_if.cmd_ready), 0);
            if (i == 1) chk("bp_stray_pulse", 32'(stray_done), 1);
            if (i == 2) chk("bp_stray_clear", 32'(stray_done), 0);
            u_if.done   = (i == 0);
            u_if.result = 16'hDEAD;
            @(negedge clk);
        end
        u_if.done = 1'b0;
        get_rsp("bp");

        // reset in the second start cycle of a MUL aborts it
        send(3'd4, 8'h10, 8'h10);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_start_low", 32'(u_if.start), 0);
        chk("rst_no_rsp", 32'(u_if.rsp_valid), 0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("rst_still_no_rsp", 32'(u_if.rsp_valid), 0);
        send(3'd1, 8'h01, 8'h02);
        sb.push_back('{16'h0003, 2'd0});
        alu_respond("post_rst_add", 1, alu_fn(3'd1, 8'h01, 8'h02));
        get_rsp("post_rst_add");
        chk("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
